// File: rtl/display_pkg.sv
// Shared constants and helpers for the BCD seven-segment display scanner.
// Segment codes are logical (1 = lit), ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Decimal digits needed to show the largest unsigned value of bin_width bits.
    function automatic int unsigned bcd_nibbles(input int unsigned bin_width);
        longint unsigned max_val;
        int unsigned     n;
        if (bin_width >= 64) begin
            max_val = '1;
        end else begin
            max_val = (64'd1 << bin_width) - 64'd1;
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_val >= 64'd10) begin
                max_val = max_val / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to logical seven-segment decoder with blanking.
// Nibbles 10..15 render as a dash so corrupt input is visible on the display.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            if (nibble <= 4'd9) begin
                seg = SEG_DIGITS[nibble];
            end else begin
                seg = SEG_DASH;
            end
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner for a packed BCD word, with a shadow
// copy that only changes at frame boundaries and optional leading-zero blanking.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int NIBBLES    = bcd_nibbles(16),
    parameter int CLK_DIV    = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NIBBLES*4-1:0]   bcd,
    input  logic                   bcd_valid,
    input  logic                   blank_lz,
    output logic [6:0]             seg,
    output logic [NIBBLES-1:0]     an,
    output logic                   frame_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int BW = NIBBLES * 4;

    localparam logic [PW-1:0]      PRE_LAST    = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]      IDX_LAST    = IW'(NIBBLES - 1);
    localparam logic [6:0]         SEG_PIN_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NIBBLES-1:0] AN_PIN_OFF  = ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]      prescaler_q, prescaler_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BW-1:0]      pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic [BW-1:0]      shadow_q, shadow_d;
    logic               started_q;
    logic               wrap_q;
    logic               frame_start_q;
    logic [6:0]         seg_q;
    logic [NIBBLES-1:0] an_q;

    logic               tick;
    logic               boundary;
    logic [NIBBLES-1:0] zero_from;
    logic [3:0]         cur_digit;
    logic [NIBBLES-1:0] cur_onehot;
    logic               cur_lz;
    logic               cur_blank;
    logic [6:0]         cur_seg;
    logic [NIBBLES-1:0] cur_an;

    assign tick     = (prescaler_q == PRE_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    always_comb begin
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // A strobe coinciding with the boundary bypasses the pending register.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        shadow_d   = shadow_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (bcd_valid) begin
                shadow_d = bcd;
            end else if (pend_vld_q) begin
                shadow_d = pend_q;
            end
        end else if (bcd_valid) begin
            pend_d     = bcd;
            pend_vld_d = 1'b1;
        end
    end

    // zero_from[i]: shadow digits i..NIBBLES-1 are all zero.
    always_comb begin
        zero_from = '0;
        zero_from[NIBBLES-1] = (shadow_q[BW-1 -: 4] == 4'h0);
        for (int i = NIBBLES - 2; i >= 0; i--) begin
            zero_from[i] = (shadow_q[i*4 +: 4] == 4'h0) && zero_from[i+1];
        end
    end

    always_comb begin
        cur_digit  = 4'h0;
        cur_onehot = '0;
        cur_lz     = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit     = shadow_q[i*4 +: 4];
                cur_onehot[i] = 1'b1;
                cur_lz        = zero_from[i];
            end
        end
    end

    // Outputs stay dark until the first tick has selected digit 0.
    assign cur_blank = !started_q || (blank_lz && (idx_q != '0) && cur_lz);
    assign cur_an    = cur_blank ? '0 : cur_onehot;

    seg7_decode u_decode (
        .nibble (cur_digit),
        .blank  (cur_blank),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            idx_q       <= IDX_LAST;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            shadow_q    <= '0;
            started_q   <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            shadow_q    <= shadow_d;
            if (tick) begin
                started_q <= 1'b1;
            end
        end
    end

    // wrap_q marks the boundary edge; frame_start follows it to line up with digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q        <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_PIN_OFF;
            an_q          <= AN_PIN_OFF;
        end else begin
            wrap_q        <= boundary;
            frame_start_q <= wrap_q;
            seg_q         <= ACTIVE_LOW ? ~cur_seg : cur_seg;
            an_q          <= ACTIVE_LOW ? ~cur_an : cur_an;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed seven-segment driver that consumes the packed BCD word produced by the binary-to-BCD converter and scans it onto a common-anode/cathode display, one digit at a time. It holds a tear-free shadow copy of the BCD value, updated only at frame boundaries. It also performs leading-zero blanking and segment decoding, and produces registered segment and digit-enable outputs for the board pins.

## Interface
- NIBBLES, 5, number of BCD digits (matches converter output for 16-bit input); ≥ 1
- CLK_DIV, 100000, clock cycles each digit is driven; ≥ 2
- ACTIVE_LOW, 1, 1 = seg and an pins active-low, 0 = active-high
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bcd  in  NIBBLES*4  packed BCD, digit i in bcd[4i+3:4i], digit 0 least significant
- bcd_valid  in  1  one-cycle strobe: capture bcd
- blank_lz  in  1  1 = blank leading zeros; sampled continuously
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- an  out  NIBBLES  one-hot digit enable, registered
- frame_start  out  1  one-cycle pulse when scanning wraps to digit 0

## Operation
- Prescaler counts 0..CLK_DIV-1 and wraps; tick = (prescaler == CLK_DIV-1).
- Digit index idx advances on tick, NIBBLES-1 wraps to 0. Reset value of idx is NIBBLES-1, so the first tick is a frame boundary.
- Capture: bcd_valid loads the pending register and sets the pending flag. Consecutive strobes overwrite it; last value wins.
- Frame boundary (tick with idx == NIBBLES-1): if bcd_valid is high in the same cycle, the shadow loads bcd directly. Otherwise, if pending is set, the shadow loads the pending register. In both cases pending clears. The shadow never changes mid-frame.
- Blanking: digit i (i ≥ 1) is blanked when blank_lz=1 and shadow digits i..NIBBLES-1 are all 0. Digit 0 is never blanked.
- Blanked digit: seg all off, an all off for that slot.
- Decode, logical lit=1 (0x notation, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - nibble 10..15 = dash 40
- Pins: ACTIVE_LOW=1 inverts both seg and an after decode.
- Reset (async, any time including mid-frame):
  - prescaler 0, idx NIBBLES-1, shadow 0, pending 0, frame_start 0
  - seg and an off: 7F and all-ones if ACTIVE_LOW, else 00 and all-zeros
  - No pending capture survives reset.

## Timing
- tick at edge T advances idx. seg/an reflect the new idx and the current shadow at edge T+1: 1-cycle latency.
- frame_start is high for exactly the cycle after the edge where idx wraps to 0, aligned with seg/an showing digit 0.
- Shadow loaded at a boundary edge is visible on digit 0 at the next edge.
- After reset release, outputs stay off until the first tick. First tick is at edge CLK_DIV. Digit 0 is driven from edge CLK_DIV+1.
- Frame period: NIBBLES*CLK_DIV cycles. Each digit is driven for exactly CLK_DIV cycles.
- bcd_valid has no backpressure and is accepted every cycle.

## Structure
- Package display_pkg:
  - SEG_OFF and SEG_DASH constants
  - ten-entry digit-to-segment constant table
  - helper function computing NIBBLES from converter input width
- Sub-module seg7_decode: combinational 4-bit nibble plus blank → 7-bit logical segments. Instantiated once, on the muxed digit.
- Top holds prescaler, idx, pending/shadow registers, blanking logic, and output registers.

## Test plan
Benches use NIBBLES=5, CLK_DIV=4.
- Basic scan: ACTIVE_LOW=0, bcd=20'h12345 strobed once, blank_lz=0. Second frame must show:
  - digit 0: seg 6D, an 00001
  - digit 1: seg 66, an 00010
  - digit 4: seg 06, an 10000
  - each digit held 4 cycles.
- Leading-zero blanking, blank_lz=1:
  - bcd=20'h00042: digits 2..4 give seg 00 and an 00000; digit 1=66, digit 0=5B.
  - bcd=0: only digit 0 lit, showing 3F.
- Invalid nibble: bcd=20'h0A000, blank_lz=1 → digit 3 shows 40; digit 4 blanked.
- Tear-free update: strobe 20'h99999 while digit 2 is driven in a frame showing 20'h11111:
  - digits 3 and 4 of that frame still show 06;
  - next frame shows 6F on all digits;
  - frame_start pulses once per 20 cycles.
- Boundary coincidence: strobe 20'h00007 on the exact tick with idx==4 → next frame digit 0 shows 07 with no extra frame delay.
- Reset mid-frame: ACTIVE_LOW=1, assert rst_n at digit 2 →
  - seg 7F and an 11111 immediately (asynchronous);
  - after release, outputs off for 4 cycles, then digit 0 shows 40 inverted (3F lit as 0, i.e. pin value 40);
  - the pending value strobed before reset is discarded.
